// File: rtl/vset_ctrl_pkg.sv
// Shared constants, FSM state encoding and instruction-variant decode for the
// vector-configuration controller.
package vset_ctrl_pkg;

   localparam logic [6:0] OPC_OP_V   = 7'b1010111;
   localparam logic [2:0] F3_OPCFG   = 3'b111;

   localparam int VT_VLMUL_LSB = 0;
   localparam int VT_VSEW_LSB  = 3;
   localparam int VT_RSV_LSB   = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      VAR_VSETVLI  = 2'd0,
      VAR_VSETIVLI = 2'd1,
      VAR_VSETVL   = 2'd2
   } variant_e;

   // Anything that is not an OPCFG word is handled like vsetvl.
   function automatic variant_e decode_variant(input logic [31:0] instr);
      if (instr[6:0] != OPC_OP_V || instr[14:12] != F3_OPCFG) return VAR_VSETVL;
      if (!instr[31]) return VAR_VSETVLI;
      if (instr[30])  return VAR_VSETIVLI;
      return VAR_VSETVL;
   endfunction

endpackage

// File: rtl/vset_ctrl_if.sv
// Request/response channel between decode (master) and the vset controller (slave).
interface vset_ctrl_if #(
   parameter int XLEN = 32
);
   logic            req_valid;
   logic            req_ready;
   logic [31:0]     instr;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic            resp_valid;
   logic            resp_ready;
   logic [4:0]      rd_addr;
   logic            rd_we;
   logic [XLEN-1:0] rd_wdata;

   modport master (
      output req_valid, instr, rs1_data, rs2_data, resp_ready,
      input  req_ready, resp_valid, rd_addr, rd_we, rd_wdata
   );

   modport slave (
      input  req_valid, instr, rs1_data, rs2_data, resp_ready,
      output req_ready, resp_valid, rd_addr, rd_we, rd_wdata
   );
endinterface

// File: rtl/vset_ctrl_vlmax_calc.sv
// VLMAX and vtype legality from (vsew, vlmul); purely combinational, log2-based,
// shared with the vector-unit decoder.
module vset_ctrl_vlmax_calc #(
   parameter int VLEN = 128,
   parameter int ELEN = 32,
   parameter int XLEN = 32
) (
   input  logic [2:0]      vsew,
   input  logic [2:0]      vlmul,
   output logic [XLEN-1:0] vlmax,
   output logic            vtype_ill
);
   localparam int LG_VLEN = $clog2(VLEN);
   localparam int LG_ELEN = $clog2(ELEN);

   int lg_sew;
   int lg_lmul;
   int lg_vlmax;

   always_comb begin
      lg_sew   = 3 + int'(vsew);
      // Fractional encodings 101/110/111 are -3/-2/-1 in log2 terms.
      lg_lmul  = vlmul[2] ? int'(vlmul) - 8 : int'(vlmul);
      lg_vlmax = LG_VLEN - lg_sew + lg_lmul;

      vlmax = '0;
      if (lg_vlmax >= 0 && lg_vlmax < XLEN) begin
         vlmax = XLEN'(1) << lg_vlmax;
      end

      vtype_ill = vsew[2]
                | (lg_sew > LG_ELEN)
                | (vlmul == 3'b100)
                | (vlmul[2] && (lg_sew > LG_ELEN + lg_lmul))
                | (vlmax == '0);
   end

endmodule

// File: rtl/vset_ctrl.sv
// Vector-configuration controller: executes vsetvli/vsetivli/vsetvl, holds the
// architectural vl/vtype pair and returns the new vl for rd writeback.
//
// state | meaning
// IDLE  | ready for a request; instr/rs1/rs2 latched on accept
// CALC  | decode vtype and AVL, compute VLMAX and new vl; commit vl/vtype
// RESP  | result held on the response channel until resp_ready
module vset_ctrl
   import vset_ctrl_pkg::*;
#(
   parameter int VLEN = 128,
   parameter int ELEN = 32,
   parameter int XLEN = 32
) (
   input  logic            clock,
   input  logic            reset,
   vset_ctrl_if.slave      bus,
   output logic [XLEN-1:0] vl,
   output logic [XLEN-1:0] vtype,
   output logic            busy
);
   localparam logic [XLEN-1:0] VILL_VTYPE = {1'b1, {(XLEN-1){1'b0}}};

   state_e          state_q,      state_d;
   logic [31:0]     instr_q,      instr_d;
   logic [XLEN-1:0] rs1_q,        rs1_d;
   logic [XLEN-1:0] rs2_q,        rs2_d;
   logic [XLEN-1:0] vl_q,         vl_d;
   logic [XLEN-1:0] vtype_q,      vtype_d;
   logic            resp_valid_q, resp_valid_d;
   logic            rd_we_q,      rd_we_d;
   logic [4:0]      rd_addr_q,    rd_addr_d;
   logic [XLEN-1:0] rd_wdata_q,   rd_wdata_d;

   variant_e        variant;
   logic [4:0]      rd_f;
   logic [4:0]      rs1_f;
   logic [XLEN-1:0] vtype_raw;
   logic [XLEN-1:0] avl;
   logic            keep_vl;
   logic [XLEN-1:0] vlmax;
   logic            calc_ill;
   logic            vill;
   logic [XLEN-1:0] new_vl;
   logic [XLEN-1:0] new_vtype;

   always_comb begin
      variant = decode_variant(instr_q);
      rd_f    = instr_q[11:7];
      rs1_f   = instr_q[19:15];

      case (variant)
         VAR_VSETVLI:  vtype_raw = XLEN'(instr_q[30:20]);
         VAR_VSETIVLI: vtype_raw = XLEN'(instr_q[29:20]);
         default:      vtype_raw = rs2_q;
      endcase

      // rs1=x0 with rd=x0 means "change vtype, keep vl".
      keep_vl = (variant != VAR_VSETIVLI) && (rs1_f == 5'd0) && (rd_f == 5'd0);

      if (variant == VAR_VSETIVLI) avl = XLEN'(rs1_f);
      else if (rs1_f != 5'd0)      avl = rs1_q;
      else if (rd_f != 5'd0)       avl = '1;
      else                         avl = vl_q;
   end

   vset_ctrl_vlmax_calc #(
      .VLEN (VLEN),
      .ELEN (ELEN),
      .XLEN (XLEN)
   ) u_vlmax_calc (
      .vsew      (vtype_raw[VT_VSEW_LSB +: 3]),
      .vlmul     (vtype_raw[VT_VLMUL_LSB +: 3]),
      .vlmax     (vlmax),
      .vtype_ill (calc_ill)
   );

   always_comb begin
      vill = calc_ill
           | (|vtype_raw[XLEN-2:VT_RSV_LSB])
           | (keep_vl && (vl_q > vlmax));

      if (vill) begin
         new_vl    = '0;
         new_vtype = VILL_VTYPE;
      end else begin
         new_vl    = (avl < vlmax) ? avl : vlmax;
         new_vtype = vtype_raw & ~VILL_VTYPE;
      end
   end

   always_comb begin
      state_d      = state_q;
      instr_d      = instr_q;
      rs1_d        = rs1_q;
      rs2_d        = rs2_q;
      vl_d         = vl_q;
      vtype_d      = vtype_q;
      resp_valid_d = resp_valid_q;
      rd_we_d      = rd_we_q;
      rd_addr_d    = rd_addr_q;
      rd_wdata_d   = rd_wdata_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               instr_d = bus.instr;
               rs1_d   = bus.rs1_data;
               rs2_d   = bus.rs2_data;
               state_d = ST_CALC;
            end
         end
         ST_CALC: begin
            vl_d         = new_vl;
            vtype_d      = new_vtype;
            rd_wdata_d   = new_vl;
            rd_addr_d    = rd_f;
            rd_we_d      = (rd_f != 5'd0);
            resp_valid_d = 1'b1;
            state_d      = ST_RESP;
         end
         ST_RESP: begin
            if (bus.resp_ready) begin
               resp_valid_d = 1'b0;
               rd_we_d      = 1'b0;
               state_d      = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         instr_q      <= '0;
         rs1_q        <= '0;
         rs2_q        <= '0;
         vl_q         <= '0;
         vtype_q      <= VILL_VTYPE;
         resp_valid_q <= 1'b0;
         rd_we_q      <= 1'b0;
         rd_addr_q    <= '0;
         rd_wdata_q   <= '0;
      end else begin
         state_q      <= state_d;
         instr_q      <= instr_d;
         rs1_q        <= rs1_d;
         rs2_q        <= rs2_d;
         vl_q         <= vl_d;
         vtype_q      <= vtype_d;
         resp_valid_q <= resp_valid_d;
         rd_we_q      <= rd_we_d;
         rd_addr_q    <= rd_addr_d;
         rd_wdata_q   <= rd_wdata_d;
      end
   end

   assign bus.req_ready  = (state_q == ST_IDLE);
   assign bus.resp_valid = resp_valid_q;
   assign bus.rd_we      = rd_we_q;
   assign bus.rd_addr    = rd_addr_q;
   assign bus.rd_wdata   = rd_wdata_q;
   assign vl             = vl_q;
   assign vtype          = vtype_q;
   assign busy           = (state_q != ST_IDLE);

endmodule
